// File: rtl/fft_peak_tracker.sv
// Spectral peak tracker: buffers the positive half of one FFT magnitude frame, then finds
// the main and secondary peaks, flags third-harmonic content and converts bin indices to Hz.
module fft_peak_tracker #(
    parameter int DATA_W     = 16,
    parameter int N_POINTS   = 1024,
    parameter int ADDR_W     = 10,
    parameter int FS_HZ      = 1000000,
    parameter int FREQ_W     = 32,
    parameter int MIN_SEP    = 2,
    parameter int REL_SHIFT  = 3,
    parameter int HARM_TOL   = 3,
    parameter int HARM_SHIFT = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    output logic              s_ready,
    output logic              busy,
    output logic              res_valid,
    output logic [DATA_W-1:0] peak1_val,
    output logic [DATA_W-1:0] peak2_val,
    output logic [ADDR_W-1:0] peak1_idx,
    output logic [ADDR_W-1:0] peak2_idx,
    output logic [FREQ_W-1:0] peak1_freq,
    output logic [FREQ_W-1:0] peak2_freq,
    output logic              peak1_harm,
    output logic              peak2_harm,
    output logic              peak2_valid,
    output logic [2:0]        dbg_state
);
    localparam int HALF   = N_POINTS / 2;
    localparam int RA_W   = ADDR_W - 1;
    localparam int WIN    = 2 * HARM_TOL + 1;
    localparam int PROD_W = ADDR_W + 33;
    localparam int HX_W   = DATA_W + HARM_SHIFT;

    typedef enum logic [2:0] {
        S_IDLE, S_CAPTURE, S_SCAN2, S_HARM1, S_HARM2, S_CALC, S_DONE
    } state_t;

    state_t r_state, w_next;
    logic [ADDR_W-1:0] r_k, r_cnt;
    logic [DATA_W-1:0] r_val1, r_val2, r_h1, r_h2, r_rdata;
    logic [ADDR_W-1:0] r_idx1, r_idx2;
    logic [FREQ_W-1:0] r_f1;
    logic              r_rd_ok;
    logic [DATA_W-1:0] r_mem [HALF];

    // s_valid/s_ready: a sample transfers on a rising edge where both are high; the
    // source holds s_data stable while s_valid is high and s_ready is low.
    logic w_acc, w_we, w_rd_ok, w_sep, w_flag1, w_flag2, w_p2v, w_load;
    logic [RA_W-1:0]   w_raddr;
    logic [ADDR_W-1:0] w_hidx, w_midx;
    logic [DATA_W-1:0] w_rdv;
    logic [PROD_W-1:0] w_prod;
    logic [FREQ_W-1:0] w_freq;
    logic [HX_W-1:0]   w_h1x, w_h2x, w_v1x, w_v2x;
    int                w_ha, w_dist;

    assign s_ready   = (r_state == S_IDLE) || (r_state == S_CAPTURE);
    assign busy      = ~s_ready;
    assign dbg_state = r_state;
    assign w_acc     = s_valid && s_ready;
    assign w_we      = w_acc && (r_k != '0) && (r_k < ADDR_W'(HALF));
    assign w_rdv     = r_rd_ok ? r_rdata : '0;
    assign w_dist    = int'(r_cnt) - int'(r_idx1);
    assign w_sep     = (w_dist > MIN_SEP) || (w_dist < -MIN_SEP);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (w_acc) w_next = S_CAPTURE;
            S_CAPTURE: if (w_acc && r_k == ADDR_W'(N_POINTS - 1)) w_next = S_SCAN2;
            S_SCAN2:   if (r_cnt == ADDR_W'(HALF - 1)) w_next = S_HARM1;
            S_HARM1:   if (r_cnt == ADDR_W'(WIN)) w_next = S_HARM2;
            S_HARM2:   if (r_cnt == ADDR_W'(WIN)) w_next = S_CALC;
            S_CALC:    if (r_cnt == ADDR_W'(1)) w_next = S_DONE;
            S_DONE:    w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    // Read issued in cycle c returns in cycle c+1; r_rd_ok marks returns that are real bins.
    always_comb begin
        w_hidx  = (r_state == S_HARM2) ? r_idx2 : r_idx1;
        w_ha    = 3 * int'(w_hidx) - HARM_TOL + int'(r_cnt);
        w_raddr = '0;
        w_rd_ok = 1'b0;
        if (r_state == S_SCAN2) begin
            w_raddr = RA_W'(r_cnt + ADDR_W'(1));
            w_rd_ok = (r_cnt < ADDR_W'(HALF - 1));
        end else if (r_state == S_HARM1 || r_state == S_HARM2) begin
            w_raddr = RA_W'(w_ha);
            w_rd_ok = (w_hidx != '0) && (r_cnt < ADDR_W'(WIN)) && (w_ha >= 1) && (w_ha < HALF);
        end
    end

    always_ff @(posedge clk) begin
        if (w_we) r_mem[r_k[RA_W-1:0]] <= s_data;
        r_rdata <= r_mem[w_raddr];
    end

    assign w_h1x   = {r_h1, {HARM_SHIFT{1'b0}}};
    assign w_h2x   = {r_h2, {HARM_SHIFT{1'b0}}};
    assign w_v1x   = HX_W'(r_val1);
    assign w_v2x   = HX_W'(r_val2);
    assign w_flag1 = (r_idx1 != '0) && (w_h1x >= w_v1x);
    assign w_flag2 = (r_idx2 != '0) && (w_h2x >= w_v2x);
    assign w_p2v   = (r_val2 > (r_val1 >> REL_SHIFT)) && (r_idx1 != '0);

    // Single shared multiplier: peak1 in the first CALC cycle, peak2 in the second.
    assign w_midx = (r_cnt == '0) ? r_idx1 : r_idx2;
    assign w_prod = PROD_W'(w_midx) * PROD_W'(FS_HZ) + PROD_W'(HALF);
    assign w_freq = FREQ_W'(w_prod >> ADDR_W);
    assign w_load = (r_state == S_CALC) && (w_next == S_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_k     <= '0;
            r_cnt   <= '0;
            r_rd_ok <= 1'b0;
            r_val1  <= '0;
            r_idx1  <= '0;
            r_val2  <= '0;
            r_idx2  <= '0;
            r_h1    <= '0;
            r_h2    <= '0;
            r_f1    <= '0;
        end else begin
            r_state <= w_next;
            r_rd_ok <= w_rd_ok;
            r_cnt   <= (w_next != r_state) ? '0 : r_cnt + ADDR_W'(1);
            if (w_acc) r_k <= r_k + ADDR_W'(1);
            case (r_state)
                S_IDLE: begin
                    r_val1 <= '0;
                    r_idx1 <= '0;
                    r_val2 <= '0;
                    r_idx2 <= '0;
                    r_h1   <= '0;
                    r_h2   <= '0;
                end
                S_CAPTURE: if (w_we && s_data > r_val1) begin
                    r_val1 <= s_data;
                    r_idx1 <= r_k;
                end
                S_SCAN2: if (r_rd_ok && w_sep && w_rdv > r_val2) begin
                    r_val2 <= w_rdv;
                    r_idx2 <= r_cnt;
                end
                S_HARM1: if (r_rd_ok && w_rdv > r_h1) r_h1 <= w_rdv;
                S_HARM2: if (r_rd_ok && w_rdv > r_h2) r_h2 <= w_rdv;
                S_CALC:  if (r_cnt == '0) r_f1 <= w_freq;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid   <= 1'b0;
            peak1_val   <= '0;
            peak1_idx   <= '0;
            peak1_freq  <= '0;
            peak1_harm  <= 1'b0;
            peak2_val   <= '0;
            peak2_idx   <= '0;
            peak2_freq  <= '0;
            peak2_harm  <= 1'b0;
            peak2_valid <= 1'b0;
        end else begin
            res_valid <= w_load;
            if (w_load) begin
                peak1_val   <= r_val1;
                peak1_idx   <= r_idx1;
                peak1_freq  <= r_f1;
                peak1_harm  <= w_flag1;
                peak2_valid <= w_p2v;
                peak2_val   <= w_p2v ? r_val2  : r_val1;
                peak2_idx   <= w_p2v ? r_idx2  : r_idx1;
                peak2_freq  <= w_p2v ? w_freq  : r_f1;
                peak2_harm  <= w_p2v ? w_flag2 : w_flag1;
            end
        end
    end
endmodule
